// File: rtl/iob_axi_wr_burst_split_if.sv
// Bundle of command, data-stream and converter-side signals for the write burst splitter.
// The slave modport is the splitter's view; the master modport is the view of whatever
// drives commands/data and plays the downstream converter.
interface iob_axi_wr_burst_split_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic                cmd_valid;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [CNT_W-1:0]    cmd_nwords;
    logic                cmd_ready;
    logic                busy;
    logic                done;
    logic                err;

    logic                d_valid;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic                d_ready;

    logic [7:0]          wr_length;
    logic                wr_ready;
    logic                wr_error;

    logic                m_valid;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_ready;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_nwords,
        output cmd_ready, busy, done, err,
        input  d_valid, d_wdata, d_wstrb,
        output d_ready,
        output wr_length,
        input  wr_ready, wr_error,
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_nwords,
        input  cmd_ready, busy, done, err,
        output d_valid, d_wdata, d_wstrb,
        input  d_ready,
        input  wr_length,
        output wr_ready, wr_error,
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready
    );
endinterface

// File: rtl/iob_axi_wr_burst_split.sv
// Splits one native write command into AXI-legal bursts (bounded by MAX_BURST beats and
// never crossing a BOUNDARY-byte line), streams each burst's data to the native-to-AXI
// converter and waits for its write response before launching the next burst.
module iob_axi_wr_burst_split #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BURST = 256,
    parameter int BOUNDARY  = 4096
) (
    input logic                     clk,
    input logic                     rst,
    iob_axi_wr_burst_split_if.slave bus
);
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int BND_W      = $clog2(BOUNDARY);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CALC      = 2'd1;
    localparam logic [1:0] ST_BURST     = 2'd2;
    localparam logic [1:0] ST_WAIT_RESP = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [CNT_W-1:0]  remaining;
    logic [8:0]        beat_cnt;
    logic [7:0]        wr_length_q;
    logic              seen_busy;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [8:0]        burst_now;
    logic [8:0]        burst_len;
    logic              m_valid_w;
    logic              beat_fire;
    logic              last_beat;

    // Beats in the next burst: smallest of words left, MAX_BURST and beats to the boundary.
    // Only the low BND_W address bits matter for the boundary distance.
    function automatic logic [8:0] min_burst(input logic [CNT_W-1:0] rem,
                                             input logic [BND_W-1:0] addr_low);
        logic [BND_W:0] dist_bytes;
        logic [BND_W:0] dist_beats;
        logic [31:0]    limit;
        dist_bytes = (BND_W+1)'(BOUNDARY) - {1'b0, addr_low};
        dist_beats = dist_bytes >> BEAT_SHIFT;
        limit      = 32'(MAX_BURST);
        if (32'(dist_beats) < limit) limit = 32'(dist_beats);
        if (32'(rem) < limit) limit = 32'(rem);
        return limit[8:0];
    endfunction

    assign burst_now = min_burst(remaining, addr_q[BND_W-1:0]);
    assign burst_len = {1'b0, wr_length_q} + 9'd1;
    assign m_valid_w = (state == ST_BURST) & bus.d_valid;
    assign beat_fire = m_valid_w & bus.m_ready;
    assign last_beat = beat_fire & (beat_cnt == {1'b0, wr_length_q});

    assign bus.cmd_ready = (state == ST_IDLE) & ~busy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.d_ready   = beat_fire;
    assign bus.wr_length = wr_length_q;
    assign bus.m_valid   = m_valid_w;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = bus.d_wdata;
    assign bus.m_wstrb   = bus.d_wstrb;

    // Command sequencing: accept, size each burst, count beats, collect the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            m_addr_q    <= '0;
            remaining   <= '0;
            beat_cnt    <= '0;
            wr_length_q <= '0;
            seen_busy   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // busy still set here only after a zero-length command; drop it now
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (bus.cmd_valid) begin
                        addr_q    <= bus.cmd_addr & ~ADDR_W'(BEAT_BYTES - 1);
                        remaining <= bus.cmd_nwords;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        if (bus.cmd_nwords == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    wr_length_q <= 8'(burst_now - 9'd1);
                    m_addr_q    <= addr_q;
                    seen_busy   <= 1'b0;
                    beat_cnt    <= '0;
                    if (bus.wr_ready) state <= ST_BURST;
                end
                ST_BURST: begin
                    if (!bus.wr_ready) seen_busy <= 1'b1;
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (last_beat) begin
                            addr_q    <= addr_q + (ADDR_W'(burst_len) << BEAT_SHIFT);
                            remaining <= remaining - CNT_W'(burst_len);
                            state     <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    // The converter must be seen busy before its ready counts as the response
                    if (!bus.wr_ready) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        err_q <= err_q | bus.wr_error;
                        if (remaining != '0) begin
                            state <= ST_CALC;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_axi_wr_burst_split.sv
// Bench for the write burst splitter: drives commands and a native data stream, plays the
// downstream converter, and compares every beat against bursts computed from plain address
// arithmetic.
module tb_iob_axi_wr_burst_split;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    iob_axi_wr_burst_split_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();

    iob_axi_wr_burst_split #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(16), .MAX_BURST(256), .BOUNDARY(4096)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        bus.d_valid = 1'b1;
        bus.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        n_tests++; if (bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready: got %b expected 0", bus.d_ready); end
        n_tests++; if (bus.wr_length !== 8'd0) begin n_fail++; $display("FAIL reset_wr_length: got %0d expected 0", bus.wr_length); end
        n_tests++; if (bus.m_addr !== 32'd0) begin n_fail++; $display("FAIL reset_m_addr: got %0h expected 0", bus.m_addr); end
        rst = 1'b0;
        bus.d_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.cmd_ready !== 1'b1 || bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: cmd_ready %b m_valid %b expected 1 0", bus.cmd_ready, bus.m_valid); end
    endtask

    // Issue one command (nwords > 0) and follow it to done, checking every beat.
    task automatic run_cmd(input string name, input logic [31:0] addr, input int nwords,
                           input bit gaps, input int err_idx, input bit check_lat);
        logic [31:0] exp_addr[$];
        int          exp_len[$];
        logic [31:0] data[$];
        logic [3:0]  strb[$];
        logic [31:0] a;
        int rem, lim, len, idx, b, beat_in, conv_cnt, resp_idx, pulses;
        int first_beat, last_resp_k, done_k;
        bit resp_due, exp_err;

        a = addr & 32'hFFFF_FFFC;
        rem = nwords;
        while (rem > 0) begin
            lim = (4096 - int'(a % 4096)) / 4;
            len = rem;
            if (len > 256) len = 256;
            if (len > lim) len = lim;
            exp_addr.push_back(a);
            exp_len.push_back(len);
            a = a + 32'(len * 4);
            rem = rem - len;
        end
        for (int i = 0; i < nwords; i++) begin
            data.push_back($urandom);
            strb.push_back(4'($urandom));
        end
        exp_err = (err_idx >= 0) && (err_idx < exp_len.size());

        bus.wr_ready = 1'b1;
        bus.wr_error = 1'b0;
        bus.d_valid = 1'b0;
        bus.m_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = addr;
        bus.cmd_nwords = 16'(nwords);
        #1;
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s cmd_ready: got %b expected 1", name, bus.cmd_ready); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_tests++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL %s accepted: busy %b cmd_ready %b expected 1 0", name, bus.busy, bus.cmd_ready); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL %s err_cleared: got %b expected 0", name, bus.err); end

        idx = 0; b = 0; beat_in = 0; conv_cnt = 0; resp_idx = 0; pulses = 0;
        first_beat = -1; last_resp_k = -1; done_k = -1; resp_due = 1'b0;
        for (int k = 0; k < 20000 && done_k < 0; k++) begin
            // converter: busy for a few cycles after each burst, then respond
            if (conv_cnt > 0) begin
                bus.wr_ready = 1'b0;
                conv_cnt--;
                if (conv_cnt == 0) resp_due = 1'b1;
            end else if (resp_due) begin
                bus.wr_ready = 1'b1;
                bus.wr_error = (resp_idx == err_idx);
                resp_idx++;
                resp_due = 1'b0;
                if (resp_idx == exp_len.size()) last_resp_k = k;
            end
            if (idx < nwords) begin
                bus.d_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.d_wdata = data[idx];
                bus.d_wstrb = strb[idx];
            end else begin
                bus.d_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.d_wdata = $urandom;
                bus.d_wstrb = 4'($urandom);
            end
            bus.m_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            n_tests++; if (!bus.d_valid && bus.m_valid) begin n_fail++; $display("FAIL %s m_valid_without_d_valid: got 1 expected 0", name); end
            n_tests++; if (bus.d_ready !== (bus.m_valid & bus.m_ready)) begin n_fail++; $display("FAIL %s d_ready: got %b expected %b", name, bus.d_ready, bus.m_valid & bus.m_ready); end
            if (bus.d_ready === 1'b1) pulses++;
            if (beat_in > 0 && b < exp_len.size()) begin
                n_tests++; if (bus.m_addr !== exp_addr[b] || bus.wr_length !== 8'(exp_len[b] - 1)) begin n_fail++; $display("FAIL %s burst_hold: m_addr %0h wr_length %0d expected %0h %0d", name, bus.m_addr, bus.wr_length, exp_addr[b], exp_len[b] - 1); end
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                if (first_beat < 0) first_beat = k;
                n_tests++;
                if (idx >= nwords || b >= exp_len.size()) begin
                    n_fail++; $display("FAIL %s extra_beat: beat %0d expected at most %0d beats", name, idx, nwords);
                end else begin
                    if (bus.m_wdata !== data[idx] || bus.m_wstrb !== strb[idx] || bus.m_addr !== exp_addr[b] || bus.wr_length !== 8'(exp_len[b] - 1)) begin
                        n_fail++;
                        $display("FAIL %s beat%0d: data %0h strb %0h m_addr %0h wr_length %0d expected %0h %0h %0h %0d",
                                 name, idx, bus.m_wdata, bus.m_wstrb, bus.m_addr, bus.wr_length, data[idx], strb[idx], exp_addr[b], exp_len[b] - 1);
                    end
                    idx++;
                    beat_in++;
                    if (beat_in == exp_len[b]) begin
                        b++;
                        beat_in = 0;
                        conv_cnt = 1 + $urandom_range(0, 2);
                    end
                end
            end
            if (bus.done === 1'b1) begin
                done_k = k;
                n_tests++; if (idx !== nwords || pulses !== nwords) begin n_fail++; $display("FAIL %s beat_count: beats %0d d_ready %0d expected %0d", name, idx, pulses, nwords); end
                n_tests++; if (b !== exp_len.size()) begin n_fail++; $display("FAIL %s burst_count: got %0d expected %0d", name, b, exp_len.size()); end
                n_tests++; if (done_k !== last_resp_k + 1) begin n_fail++; $display("FAIL %s done_timing: cycle %0d expected %0d", name, done_k, last_resp_k + 1); end
                n_tests++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL %s err: got %b expected %b", name, bus.err, exp_err); end
                n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b expected 0", name, bus.busy); end
            end
            @(negedge clk);
        end
        n_tests++; if (done_k < 0) begin n_fail++; $display("FAIL %s timeout: done never seen, beats %0d expected %0d", name, idx, nwords); end
        if (check_lat) begin
            n_tests++; if (first_beat !== 1) begin n_fail++; $display("FAIL %s first_beat_latency: got %0d expected 1", name, first_beat); end
        end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse_width: got %b expected 0", name, bus.done); end
        bus.d_valid = 1'b0;
        bus.m_ready = 1'b0;
        bus.wr_ready = 1'b1;
        bus.wr_error = 1'b0;
    endtask

    task automatic test_single_burst();
        run_cmd("single_burst", 32'h0000_1000, 4, 1'b0, -1, 1'b1);
    endtask

    task automatic test_boundary_split();
        run_cmd("boundary_split", 32'h0000_0FF8, 8, 1'b0, -1, 1'b1);
    endtask

    task automatic test_max_burst();
        run_cmd("max_burst", 32'h0000_0000, 600, 1'b0, -1, 1'b1);
    endtask

    task automatic test_zero_words();
        bus.wr_ready = 1'b1;
        bus.d_valid = 1'b1;
        bus.m_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = 32'h40;
        bus.cmd_nwords = 16'd0;
        #1;
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_cmd_ready: got %b expected 1", bus.cmd_ready); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", bus.done); end
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL zero_m_valid: got %b expected 0", bus.m_valid); end
        @(negedge clk);
        n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL zero_after: done %b busy %b m_valid %b expected 0 0 0", bus.done, bus.busy, bus.m_valid); end
        @(negedge clk);
        n_tests++; if (bus.cmd_ready !== 1'b1 || bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL zero_idle: cmd_ready %b m_valid %b expected 1 0", bus.cmd_ready, bus.m_valid); end
        bus.d_valid = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_error_sticky();
        run_cmd("error_sticky", 32'h0000_0000, 600, 1'b1, 1, 1'b0);
        run_cmd("err_clear", 32'h0000_2004, 10, 1'b1, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          n;
        int          e;
        for (int t = 0; t < 8; t++) begin
            addr = 32'($urandom_range(0, 16383));
            n = $urandom_range(1, 700);
            e = $urandom_range(0, 3) - 1;
            run_cmd($sformatf("random%0d", t), addr, n, 1'b1, e, 1'b0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int cnt;
        bit hit;
        cnt = 0;
        hit = 1'b0;
        bus.wr_ready = 1'b1;
        bus.d_valid = 1'b1;
        bus.d_wdata = 32'hA5A5_0000;
        bus.d_wstrb = 4'hF;
        bus.m_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = 32'h0;
        bus.cmd_nwords = 16'd16;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            #1;
            if (cnt == 4) begin
                hit = 1'b1;
                n_tests++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_precondition: m_valid %b expected 1", bus.m_valid); end
                rst = 1'b1;
                #1;
                n_tests++; if (bus.m_valid !== 1'b0 || bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: m_valid %b d_ready %b expected 0 0", bus.m_valid, bus.d_ready); end
                n_tests++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_status: busy %b cmd_ready %b expected 0 1", bus.busy, bus.cmd_ready); end
                n_tests++; if (bus.wr_length !== 8'd0 || bus.m_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mid_regs: wr_length %0d m_addr %0h expected 0 0", bus.wr_length, bus.m_addr); end
            end else if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                cnt++;
            end
            @(negedge clk);
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL rst_mid_reach: beats %0d expected 4", cnt); end
        bus.d_valid = 1'b0;
        bus.m_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        run_cmd("after_reset", 32'h0000_0300, 20, 1'b0, -1, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_nwords = '0;
        bus.d_valid = 1'b0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;
        bus.wr_ready = 1'b1;
        bus.wr_error = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_boundary_split();
        test_max_burst();
        test_zero_words();
        test_error_sticky();
        test_random();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iob_axi_wr_burst_split.md
Name: iob_axi_wr_burst_split

Overview:
- Upstream feeder for the native-to-AXI4 write converter.
- Accepts one write command (start byte address, word count) and a native data stream.
- Splits the command into AXI-legal bursts: at most MAX_BURST beats each, and no burst crosses a BOUNDARY-byte line.
- For each burst it presents the address, wr_length and data beats to the converter, waits for the converter's write response, then launches the next burst.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; beat = DATA_W/8 bytes
- CNT_W, 16, width of command word count
- MAX_BURST, 256, max beats per burst; power of 2, ≤256
- BOUNDARY, 4096, byte boundary no burst may cross; power of 2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored (treated as 0)
- cmd_nwords  in  CNT_W  total beats to write
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, command complete
- err  out  1  error status of last command
- d_valid  in  1  data beat available
- d_wdata  in  DATA_W  data beat
- d_wstrb  in  DATA_W/8  byte strobes
- d_ready  out  1  data beat consumed
- wr_length  out  8  beats-1 of current burst
- wr_ready  in  1  converter idle/ready for new burst
- wr_error  in  1  converter error status, valid when wr_ready returns high
- m_valid  out  1  native write valid to converter
- m_addr  out  ADDR_W  burst start address, held for whole burst
- m_wdata  out  DATA_W  = d_wdata
- m_wstrb  out  DATA_W/8  = d_wstrb
- m_ready  in  1  converter accepted beat

Behaviour:
- Reset values:
  - state IDLE; cmd_ready=1; busy=0; done=0; err=0; m_valid=0; d_ready=0.
  - wr_length=0; m_addr=0; internal address/remaining/beat counters=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid: latch aligned addr and remaining=cmd_nwords; clear err; busy=1.
    - nwords=0 → done pulse next cycle, stay IDLE, no m_valid.
    - Else → CALC.
  - CALC (1 cycle):
    - burst = min(remaining, MAX_BURST, (BOUNDARY - addr mod BOUNDARY) >> log2(DATA_W/8)).
    - Register wr_length = burst-1 and m_addr = addr; clear seen_busy; beat counter=0.
    - → BURST when wr_ready=1, else hold in CALC.
  - BURST:
    - m_valid = d_valid; d_ready = m_valid & m_ready.
    - A beat completes on d_valid & m_ready; beat counter +1.
    - After the beat where counter = burst-1: addr += burst*DATA_W/8, remaining -= burst → WAIT_RESP.
  - WAIT_RESP:
    - m_valid=0, d_ready=0.
    - seen_busy is set whenever wr_ready=0 from BURST entry onward.
    - Exit when seen_busy & wr_ready; err |= wr_error (sticky within the command).
    - remaining≠0 → CALC. Else → done pulse, busy=0, IDLE.
- Timing:
  - Command accept at cycle T gives first m_valid possible at T+2, if wr_ready=1.
  - Done is asserted the cycle after WAIT_RESP exit.
- Errors do not abort; all remaining bursts are issued so the data stream is fully drained.
- m_addr and wr_length are stable from BURST entry until the next CALC.
- Address wrap past 2^ADDR_W is not checked.
- Arithmetic:
  - Beat counter is 9 bits; remaining is CNT_W bits.
  - Boundary distance is computed on the low log2(BOUNDARY) bits only.
- Reset mid-operation returns to IDLE immediately with reset values; no partial burst is tracked. The converter must share the same reset.
- cmd_valid while busy is ignored (cmd_ready=0).

Test Plan:
- DATA_W=32, cmd 0x1000 / 4 words, wr_ready high, m_ready=1 → one burst: wr_length=3, m_addr=0x1000, 4 beats in order; done after response; err=0.
- cmd 0x0FF8 / 8 words → burst 1: m_addr 0x0FF8, wr_length=1; burst 2: m_addr 0x1000, wr_length=5; 8 beats total.
- cmd 0x0 / 600 words → wr_length 255, 255, 87 at m_addr 0x000, 0x400, 0x800; exactly 600 d_ready pulses.
- cmd_nwords=0 → cmd accepted; done pulses 1 cycle later; m_valid never asserted; busy drops.
- Random d_valid/m_ready gaps, wr_error=1 on the 2nd of 3 responses → data order preserved, all bursts issued, err=1 at done; next command accept clears err to 0.
- Assert rst during BURST beat 5 of 16 → same cycle: m_valid=0, d_ready=0, busy=0, cmd_ready=1; new command after reset runs normally.
